// File: rtl/mem_data_lsu_if.sv
// Request/response bundle between the core's MEM stage and mem_data_lsu.
//   cen, wen      : active-low chip enable / write enable (0 = store)
//   addr          : byte address, ADDR_W bits
//   funct3        : RV32 access size/sign code
//   wdata         : right-aligned store data
//   ready         : request on cen/wen is taken at this edge
//   rdata, rvalid : formatted load result and its one-cycle valid pulse
//   err           : one-cycle pulse flagging a misaligned/illegal request
interface mem_data_lsu_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              cen;
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        funct3;
    logic [31:0]       wdata;
    logic              ready;
    logic [31:0]       rdata;
    logic              rvalid;
    logic              err;

    modport master (
        output cen, wen, addr, funct3, wdata,
        input  ready, rdata, rvalid, err
    );

    modport slave (
        input  cen, wen, addr, funct3, wdata,
        output ready, rdata, rvalid, err
    );
endinterface

// File: rtl/mem_data_lsu.sv
// RV32 data memory with load/store formatting.
// Single-port word array with byte-lane writes (SB/SH/SW) and registered,
// sign/zero-extended reads (LB/LH/LW/LBU/LHU). After reset an optional
// zero-fill pass clears every word before requests are accepted.
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : request/response bundle (slave side), see mem_data_lsu_if
module mem_data_lsu #(
    parameter int unsigned ADDR_W       = 10,
    parameter bit          CLEAR_ON_RST = 1'b1
) (
    input logic             clk,
    input logic             rst_n,
    mem_data_lsu_if.slave   bus
);
    localparam int unsigned WIDX_W = ADDR_W - 2;
    localparam int unsigned DEPTH  = 2 ** WIDX_W;

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_t;

    localparam state_t RST_STATE = CLEAR_ON_RST ? S_CLEAR : S_RUN;

    state_t            state_q, state_d;
    logic [WIDX_W-1:0] cnt_q, cnt_d;
    logic              rvalid_q, err_q;
    logic [31:0]       rdata_q;

    logic [31:0]       mem [DEPTH];

    logic              ready;
    logic              accept;
    logic              legal;
    logic [WIDX_W-1:0] word_idx;
    logic [1:0]        off;

    logic              mem_we;
    logic [WIDX_W-1:0] mem_widx;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wd;

    logic [31:0]       rd_word;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       ld_data;

    assign ready    = (state_q == S_RUN);
    assign accept   = ready && !bus.cen;
    assign word_idx = bus.addr[ADDR_W-1:2];
    assign off      = bus.addr[1:0];

    // State register and clear counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == WIDX_W'(DEPTH - 1)) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // Access legality: unsigned forms exist only for loads
    always_comb begin
        legal = 1'b0;
        case (bus.funct3)
            3'b000:  legal = 1'b1;
            3'b100:  legal = bus.wen;
            3'b001:  legal = !off[0];
            3'b101:  legal = bus.wen && !off[0];
            3'b010:  legal = (off == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    // Single write port shared by the zero-fill pass and stores
    always_comb begin
        mem_we   = 1'b0;
        mem_widx = word_idx;
        mem_be   = '0;
        mem_wd   = '0;
        if (state_q == S_CLEAR) begin
            mem_we   = 1'b1;
            mem_widx = cnt_q;
            mem_be   = '1;
            mem_wd   = '0;
        end else if (accept && legal && !bus.wen) begin
            mem_we = 1'b1;
            case (bus.funct3)
                3'b000: begin
                    mem_be = 4'b0001 << off;
                    mem_wd = {4{bus.wdata[7:0]}};
                end
                3'b001: begin
                    mem_be = 4'b0011 << off;
                    mem_wd = {2{bus.wdata[15:0]}};
                end
                default: begin
                    mem_be = 4'b1111;
                    mem_wd = bus.wdata;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (mem_be[i]) begin
                    mem[mem_widx][8*i +: 8] <= mem_wd[8*i +: 8];
                end
            end
        end
    end

    // Load formatting on the word currently addressed
    assign rd_word = mem[word_idx];
    assign rd_byte = rd_word[{off, 3'b000} +: 8];
    assign rd_half = off[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        ld_data = rd_word;
        case (bus.funct3)
            3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  ld_data = {24'h000000, rd_byte};
            3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
            3'b101:  ld_data = {16'h0000, rd_half};
            default: ld_data = rd_word;
        endcase
    end

    // Response registers: rdata holds between loads, cleared on an error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            if (accept) begin
                if (!legal) begin
                    err_q   <= 1'b1;
                    rdata_q <= '0;
                end else if (bus.wen) begin
                    rvalid_q <= 1'b1;
                    rdata_q  <= ld_data;
                end
            end
        end
    end

    assign bus.ready  = ready;
    assign bus.rvalid = rvalid_q;
    assign bus.err    = err_q;
    assign bus.rdata  = rdata_q;
endmodule

// File: tb/tb_mem_data_lsu.sv
module tb_mem_data_lsu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_data_lsu_if #(.ADDR_W(10)) bus ();

    mem_data_lsu #(.ADDR_W(10), .CLEAR_ON_RST(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0]  model [1024];
    logic [31:0] exp_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_legal(input bit is_load, input logic [2:0] f3, input logic [9:0] a);
        case (f3)
            3'b000:  return 1'b1;
            3'b100:  return is_load;
            3'b001:  return a[0] == 1'b0;
            3'b101:  return is_load && a[0] == 1'b0;
            3'b010:  return a[1:0] == 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int acc_size(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    // One request in one cycle; expected response derived from the byte model
    task automatic req(input bit is_load, input logic [9:0] a, input logic [2:0] f3,
                       input logic [31:0] wd, input string tag);
        logic        exp_v, exp_e;
        logic [31:0] v;
        int          n;
        @(negedge clk);
        bus.cen = 1'b0; bus.wen = is_load; bus.addr = a; bus.funct3 = f3; bus.wdata = wd;
        exp_v = 1'b0; exp_e = 1'b0;
        n = acc_size(f3);
        if (!is_legal(is_load, f3, a)) begin
            exp_e = 1'b1;
            exp_rdata = 32'h0;
        end else if (!is_load) begin
            for (int i = 0; i < n; i++) model[int'(a) + i] = wd[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v = v | (32'(model[int'(a) + i]) << (8*i));
            if (f3 == 3'b000 && v[7])  v = v | 32'hFFFFFF00;
            if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF0000;
            exp_v = 1'b1;
            exp_rdata = v;
        end
        @(posedge clk); #1;
        bus.cen = 1'b1;
        chk({tag, "/rvalid"}, {31'b0, bus.rvalid}, {31'b0, exp_v});
        chk({tag, "/err"},    {31'b0, bus.err},    {31'b0, exp_e});
        chk({tag, "/rdata"},  bus.rdata,           exp_rdata);
    endtask

    // Release reset and count not-ready cycles while firing requests that must be dropped
    task automatic run_clear(input int abort_at, output int n);
        n = 0;
        @(negedge clk);
        rst_n = 1'b1;
        while (n < 2000) begin
            bus.cen = 1'b0; bus.wen = 1'($urandom); bus.addr = 10'($urandom);
            bus.funct3 = 3'($urandom_range(0, 7)); bus.wdata = $urandom;
            @(posedge clk); #1;
            n++;
            bus.cen = 1'b1;
            chk("clear_drop", {30'b0, bus.rvalid, bus.err}, 32'h0);
            if (bus.ready) break;
            if (n == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("abort_ready", {31'b0, bus.ready}, 32'h0);
                return;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int          n;
        logic [9:0]  a;
        logic [31:0] d;
        bus.cen = 1'b1; bus.wen = 1'b1; bus.addr = '0; bus.funct3 = '0; bus.wdata = '0;
        exp_rdata = 32'h0;
        for (int i = 0; i < 1024; i++) model[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",  {31'b0, bus.ready},  32'h0);
        chk("rst_rvalid", {31'b0, bus.rvalid}, 32'h0);
        chk("rst_err",    {31'b0, bus.err},    32'h0);
        chk("rst_rdata",  bus.rdata,           32'h0);

        run_clear(0, n);
        chk("clear_len", n, 256);

        @(negedge clk); rst_n = 1'b0;
        @(negedge clk);
        run_clear(100, n);
        chk("abort_at", n, 100);
        run_clear(0, n);
        chk("clear_len_after_abort", n, 256);

        req(1'b1, 10'h000, 3'b010, 32'h0, "lw_0x000");
        req(1'b1, 10'h3FC, 3'b010, 32'h0, "lw_0x3fc");

        req(1'b0, 10'h010, 3'b010, 32'h11223344, "sw_0x010");
        req(1'b0, 10'h012, 3'b000, 32'h000000AB, "sb_0x012");
        req(1'b1, 10'h010, 3'b010, 32'h0, "lw_0x010");
        chk("lw_0x010_val", bus.rdata, 32'h11AB3344);
        req(1'b1, 10'h012, 3'b100, 32'h0, "lbu_0x012");
        chk("lbu_0x012_val", bus.rdata, 32'h000000AB);
        req(1'b1, 10'h012, 3'b000, 32'h0, "lb_0x012");
        chk("lb_0x012_val", bus.rdata, 32'hFFFFFFAB);

        req(1'b0, 10'h022, 3'b001, 32'h00008001, "sh_0x022");
        req(1'b1, 10'h022, 3'b001, 32'h0, "lh_0x022");
        chk("lh_0x022_val", bus.rdata, 32'hFFFF8001);
        req(1'b1, 10'h022, 3'b101, 32'h0, "lhu_0x022");
        chk("lhu_0x022_val", bus.rdata, 32'h00008001);
        req(1'b1, 10'h020, 3'b001, 32'h0, "lh_0x020");

        req(1'b0, 10'h030, 3'b010, 32'hCAFEF00D, "sw_0x030");
        req(1'b1, 10'h010, 3'b010, 32'h0, "lw_prime");
        req(1'b0, 10'h031, 3'b010, 32'hDEADBEEF, "sw_mis_0x031");
        req(1'b1, 10'h033, 3'b001, 32'h0, "lh_mis_0x033");
        req(1'b1, 10'h030, 3'b010, 32'h0, "lw_0x030");
        chk("lw_0x030_val", bus.rdata, 32'hCAFEF00D);
        req(1'b1, 10'h030, 3'b011, 32'h0, "ld_f3_011");
        req(1'b0, 10'h034, 3'b100, 32'h0, "sbu_illegal");

        // Idle cycle: rvalid low, rdata holds
        req(1'b1, 10'h010, 3'b010, 32'h0, "lw_before_idle");
        @(posedge clk); #1;
        chk("idle_rvalid", {31'b0, bus.rvalid}, 32'h0);
        chk("idle_rdata",  bus.rdata,           exp_rdata);

        for (int i = 0; i < 32; i++) begin
            a = {8'($urandom), 2'b00};
            d = $urandom;
            req(1'b0, a, 3'b010, d, "b2b_sw");
            req(1'b1, a, 3'b010, 32'h0, "b2b_lw");
            chk("b2b_val", bus.rdata, d);
        end

        for (int i = 0; i < 300; i++) begin
            req(1'($urandom), 10'($urandom_range(0, 63)), 3'($urandom_range(0, 7)),
                $urandom, "rand");
        end

        // Reset with a load result on the outputs
        req(1'b1, 10'h010, 3'b010, 32'h0, "lw_before_rst");
        rst_n = 1'b0;
        #1;
        chk("rst_flight_rvalid", {31'b0, bus.rvalid}, 32'h0);
        chk("rst_flight_rdata",  bus.rdata,           32'h0);
        chk("rst_flight_ready",  {31'b0, bus.ready},  32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
